// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 host transmitter and receiver.
// Contains the FSM state encodings, status bit positions, common keyboard
// command bytes and the odd-parity helper.
package ps2_defs;

   // Transmitter FSM states; the REQ..WAIT_IDLE states are the device-clocked ones
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_DATA      = 3'd3;
   localparam logic [2:0] ST_PARITY    = 3'd4;
   localparam logic [2:0] ST_STOP      = 3'd5;
   localparam logic [2:0] ST_ACK       = 3'd6;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

   localparam int STAT_BUSY = 0;
   localparam int STAT_ERR  = 1;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   // Status register image as seen on wb_dat_o
   typedef struct packed {
      logic [5:0] rsvd;
      logic       err;
      logic       busy;
   } ps2_status_t;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clk and data pads plus a one-cycle
// pulse on every synchronised clk 1->0 transition. Also used by ps2_keyb.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic sync_clk,
   output logic sync_data,
   output logic clk_fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   // Synchroniser chains; idle bus level is high so reset to 1
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], ps2_clk_i};
         data_ff  <= {data_ff[0], ps2_data_i};
         clk_prev <= clk_ff[1];
      end
   end

   assign sync_clk  = clk_ff[1];
   assign sync_data = data_ff[1];
   assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter, Wishbone slave with one 8-bit
// register: write = command byte, read = {6'b0, err, busy}.
// Optional macro PS2_HOST_TX_TIMEOUT_EN: abort the frame with err=1 when the
// device stops clocking for TIMEOUT_CLKS cycles.
module ps2_host_tx
   import ps2_defs::*;
#(
   parameter int INHIBIT_CLKS = 10000,
   parameter int INHIBIT_W    = 14,
   parameter int TIMEOUT_CLKS = 200000,
   parameter int TIMEOUT_W    = 18
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   input  logic       wb_we_i,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   output logic       wb_ack_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   output logic       rx_inhibit_o
);

   // Counter widths must be able to hold their terminal counts
   if (INHIBIT_CLKS < 2 || INHIBIT_CLKS > (1 << INHIBIT_W)) begin : g_bad_inhibit
      $error("ps2_host_tx: INHIBIT_CLKS does not fit INHIBIT_W");
   end
   if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > (1 << TIMEOUT_W)) begin : g_bad_timeout
      $error("ps2_host_tx: TIMEOUT_CLKS does not fit TIMEOUT_W");
   end

   logic [2:0]           state;
   logic [7:0]           tx_byte;
   logic                 tx_par;
   logic [2:0]           bit_cnt;
   logic [INHIBIT_W-1:0] inh_cnt;
   logic                 busy;
   logic                 err;
   logic                 sync_clk;
   logic                 sync_data;
   logic                 clk_fall;
   logic                 wr_acc;
   logic                 to_hit;
   ps2_status_t          status;

   ps2_line_sync u_sync (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .sync_clk   (sync_clk),
      .sync_data  (sync_data),
      .clk_fall   (clk_fall)
   );

   // A write is taken only on the first cycle of the access and only when idle
   assign wr_acc = wb_stb_i & wb_cyc_i & wb_we_i & ~wb_ack_o & ~busy;

   // Single-cycle acknowledge for every access
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) wb_ack_o <= 1'b0;
      else          wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
   end

`ifdef PS2_HOST_TX_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] to_cnt;

   // Device-silence counter: cleared before REQ and on every device clock edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || state == ST_IDLE || state == ST_INHIBIT || clk_fall)
         to_cnt <= '0;
      else if (!to_hit)
         to_cnt <= to_cnt + 1'b1;
   end

   // A device edge arriving exactly at the limit still counts as activity
   assign to_hit = (state >= ST_REQ) & ~clk_fall &
                   (to_cnt == TIMEOUT_W'(TIMEOUT_CLKS - 1));
`else
   assign to_hit = 1'b0;
`endif

   // Frame sequencer: inhibit, request-to-send, then shift on device falling edges
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         err           <= 1'b0;
         ps2_clk_oe_o  <= 1'b0;
         ps2_data_oe_o <= 1'b0;
         tx_byte       <= '0;
         tx_par        <= 1'b0;
         bit_cnt       <= '0;
         inh_cnt       <= '0;
      end else if (to_hit) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         err           <= 1'b1;
         ps2_clk_oe_o  <= 1'b0;
         ps2_data_oe_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_acc) begin
                  tx_byte      <= wb_dat_i;
                  tx_par       <= odd_parity(wb_dat_i);
                  err          <= 1'b0;
                  busy         <= 1'b1;
                  ps2_clk_oe_o <= 1'b1;
                  inh_cnt      <= '0;
                  state        <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (inh_cnt == INHIBIT_W'(INHIBIT_CLKS - 1)) begin
                  ps2_clk_oe_o  <= 1'b0;
                  ps2_data_oe_o <= 1'b1;
                  state         <= ST_REQ;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
                  // start bit goes low during the last inhibit cycle, before clk is released
                  if (inh_cnt == INHIBIT_W'(INHIBIT_CLKS - 2)) ps2_data_oe_o <= 1'b1;
               end
            end
            ST_REQ: begin
               if (clk_fall) begin
                  ps2_data_oe_o <= ~tx_byte[0];
                  bit_cnt       <= 3'd1;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (clk_fall) begin
                  ps2_data_oe_o <= ~tx_byte[bit_cnt];
                  bit_cnt       <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (clk_fall) begin
                  ps2_data_oe_o <= ~tx_par;
                  state         <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (clk_fall) begin
                  ps2_data_oe_o <= 1'b0;
                  state         <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (clk_fall) begin
                  err   <= sync_data;
                  state <= ST_WAIT_IDLE;
               end
            end
            default: begin
               if (sync_clk && sync_data) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Status read-back is the live flag state
   always_comb begin
      status      = '0;
      status.busy = busy;
      status.err  = err;
   end

   assign wb_dat_o     = status;
   assign rx_inhibit_o = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks each frame out, captures
// the 11 bits at its rising clock edges and scores them against a queue of
// expected frames built from the command bytes when they are written.
module tb_ps2_host_tx;
   import ps2_defs::*;

   localparam int INH  = 10000;
   localparam int TO   = 2000;
   localparam int HALF = 20;

   typedef struct {
      logic [7:0] b;
      bit         nack;
      bit         abort;
      bit         mute;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wb_dat_i;
   logic [7:0] wb_dat_o;
   logic       wb_we_i;
   logic       wb_stb_i;
   logic       wb_cyc_i;
   logic       wb_ack_o;
   logic       ps2_clk_oe_o;
   logic       ps2_data_oe_o;
   logic       rx_inhibit_o;
   logic       dev_clk_rel = 1'b1;
   logic       dev_data_low = 1'b0;
   logic       clk_line;
   logic       data_line;

   int     n_chk = 0;
   int     n_fail = 0;
   int     dev_falls = 0;
   bit     dev_busy = 0;
   frame_t exp_q[$];

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device
   assign clk_line  = ~ps2_clk_oe_o & dev_clk_rel;
   assign data_line = ~ps2_data_oe_o & ~dev_data_low;

   ps2_host_tx #(.INHIBIT_CLKS(INH), .TIMEOUT_CLKS(TO)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wb_dat_i      (wb_dat_i),
      .wb_dat_o      (wb_dat_o),
      .wb_we_i       (wb_we_i),
      .wb_stb_i      (wb_stb_i),
      .wb_cyc_i      (wb_cyc_i),
      .wb_ack_o      (wb_ack_o),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe_o  (ps2_clk_oe_o),
      .ps2_data_oe_o (ps2_data_oe_o),
      .rx_inhibit_o  (rx_inhibit_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected line bits in transmit order: start, LSB-first data, parity, stop
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      f[9]  = (($countones(b) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Device model and frame monitor
   initial begin : device
      frame_t      fr;
      int          cnt;
      logic [10:0] cap;
      forever begin
         @(negedge clk);
         if (ps2_clk_oe_o !== 1'b1) continue;
         dev_busy = 1;
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            fr = '{b: 8'h00, nack: 1'b0, abort: 1'b1, mute: 1'b0};
         end else begin
            fr = exp_q[0];
            fr.abort = fr.abort;
         end
         cnt = 0;
         while (ps2_clk_oe_o === 1'b1 && cnt < INH + 100) begin
            cnt++;
            @(negedge clk);
         end
         check("inhibit_len", cnt, INH);
         check("start_drive", ps2_data_oe_o, 1);
         if (fr.mute) begin
            cnt = 0;
            while (rx_inhibit_o === 1'b1 && cnt < TO + 100) begin
               cnt++;
               @(negedge clk);
            end
            check("timeout_len", cnt, TO);
            check("timeout_status", wb_dat_o, 8'h02);
            check("timeout_lines", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
         end else begin
            cap    = '0;
            cap[0] = data_line;
            repeat (HALF) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
               if (k == 11 && !fr.nack) begin
                  dev_data_low = 1'b1;
                  repeat (10) @(negedge clk);
               end
               dev_clk_rel = 1'b0;
               dev_falls   = k;
               repeat (HALF) @(negedge clk);
               dev_clk_rel = 1'b1;
               if (k <= 10) cap[k] = data_line;
               repeat (HALF) @(negedge clk);
            end
            dev_data_low = 1'b0;
            if (!fr.abort) check("frame_bits", cap, model_frame(fr.b));
         end
         if (exp_q.size() != 0) fr = exp_q.pop_front();
         dev_falls = 0;
         dev_busy  = 0;
      end
   end

   task automatic wb_xfer(input bit we, input logic [7:0] d, output logic [7:0] rd);
      @(negedge clk);
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      wb_we_i  = we;
      wb_dat_i = d;
      @(negedge clk);
      check("ack_high", wb_ack_o, 1);
      rd       = wb_dat_o;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", wb_ack_o, 0);
   endtask

   task automatic read_status(input string name, input logic [7:0] exp);
      logic [7:0] rd;
      wb_xfer(1'b0, 8'h00, rd);
      check(name, rd, exp);
   endtask

   task automatic send(input logic [7:0] b, input bit nack, input bit abort, input bit mute);
      logic [7:0] rd;
      exp_q.push_back('{b: b, nack: nack, abort: abort, mute: mute});
      wb_xfer(1'b1, b, rd);
      check("accept_status", rd, 8'h01);
      check("rx_inhibit_on", rx_inhibit_o, 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((rx_inhibit_o !== 1'b0 || dev_busy) && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check(name, (n < 30000), 1);
      check("rx_inhibit_off", rx_inhibit_o, 0);
   endtask

   task automatic wait_falls(input int k);
      int n = 0;
      while (dev_falls < k && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check("wait_falls", (n < 30000), 1);
   endtask

   initial begin : stim
      logic [7:0] b;
      logic [7:0] rd;
      bit         nack;
      rst      = 1'b1;
      wb_dat_i = 8'h00;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", wb_ack_o, 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_lines", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
      check("rst_inhibit", rx_inhibit_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // Set-LEDs with an acknowledging device
      send(CMD_SET_LEDS, 0, 0, 0);
      wait_done("done_ed");
      read_status("status_ed", 8'h00);

      // Device withholds the ack bit, then a new command clears err
      b = 8'($urandom);
      send(b, 1, 0, 0);
      wait_done("done_nack");
      read_status("status_nack", 8'h02);
      send(CMD_ENABLE, 0, 0, 0);
      wait_done("done_f4");
      read_status("status_f4", 8'h00);

      // Write while busy is acked but ignored; status reads busy mid-frame
      b    = 8'($urandom);
      nack = 1'($urandom_range(0, 1));
      send(b, nack, 0, 0);
      wait_falls(3);
      repeat (5) @(negedge clk);
      wb_xfer(1'b1, 8'h12, rd);
      check("busy_write_status", rd, 8'h01);
      read_status("status_mid_frame", 8'h01);
      check("rx_inhibit_mid", rx_inhibit_o, 1);
      wait_done("done_busy_wr");
      read_status("status_busy_wr", nack ? 8'h02 : 8'h00);

      // Reset during the parity bit releases the lines at once
      b = 8'($urandom);
      send(b, 0, 1, 0);
      wait_falls(8);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_lines", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
      check("midrst_dat", wb_dat_o, 0);
      rst = 1'b0;
      wait_done("done_abort");
      send(CMD_RESET, 0, 0, 0);
      wait_done("done_ff");
      read_status("status_ff", 8'h00);

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Device never clocks after the request
      b = 8'($urandom);
      send(b, 0, 0, 1);
      wait_done("done_timeout");
      read_status("status_timeout", 8'h02);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the CPU to the keyboard.
- It is the opposite direction of ps2_keyb, which only receives, and shares the same open-drain clk/data pads.
- Wishbone I/O slave with one 8-bit register, clocked on the 100 MHz keyboard clock.
- While busy it tells ps2_keyb to ignore the line.

Parameters:
- INHIBIT_CLKS, 10000: clocks to hold PS/2 clk low before the request (100 us at 100 MHz).
- INHIBIT_W, 14: width of the inhibit counter.
- TIMEOUT_CLKS, 200000: maximum clocks between device edges (2 ms); used only with the optional feature.
- TIMEOUT_W, 18: width of the timeout counter.

Ports:
- wb_clk_i  in  1  system clock (100 MHz)
- wb_rst_i  in  1  synchronous active-high reset
- wb_dat_i  in  8  command byte to send
- wb_dat_o  out  8  status {6'b0, err, busy}
- wb_we_i  in  1  write strobe
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  registered acknowledge
- ps2_clk_i  in  1  raw PS/2 clock pad input
- ps2_data_i  in  1  raw PS/2 data pad input
- ps2_clk_oe_o  out  1  1 = pull PS/2 clk low, 0 = release
- ps2_data_oe_o  out  1  1 = pull PS/2 data low, 0 = release
- rx_inhibit_o  out  1  equals busy; ps2_keyb discards traffic while high

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, ps2_clk_oe_o=0, ps2_data_oe_o=0, busy=0, err=0, state=IDLE.
- Reset mid-frame: both lines are released on the cycle after reset is sampled; no partial bits are retried.
- Wishbone acknowledge: wb_ack_o <= stb & cyc & !wb_ack_o. Every access is acked exactly one cycle later, reads and writes alike.
- Accepting a write: a write at cycle N with busy=0 latches the byte and computes odd parity (~^byte).
  - Clears err.
  - busy=1 and ps2_clk_oe_o=1 from cycle N+1.
- Write while busy: acked, data ignored, err unchanged. A write in the same cycle that busy falls is also ignored, because busy is still 1 that cycle.
- Line input: both pads pass through a 2-flop synchroniser. A falling edge is sync_clk 1->0 between consecutive samples.
- States and transitions:
  - IDLE: both lines released.
  - INHIBIT: clk_oe=1 for INHIBIT_CLKS cycles. In the final cycle data_oe is set to 1 (start bit).
  - REQ: clk_oe=0, data_oe=1; wait for the first falling edge.
  - DATA: on each falling edge, data_oe = ~bit[k], k = 0..7 LSB first; 8 edges total, 3-bit counter.
  - PARITY: next falling edge, data_oe = ~parity.
  - STOP: next falling edge, data_oe = 0 (stop bit = 1).
  - ACK: on the 11th falling edge, sample sync_data. 0 = success; 1 = err set to 1.
  - WAIT_IDLE: wait until sync_clk=1 and sync_data=1 for one sample, then go to IDLE with busy=0.
- Line rule: data only changes in the cycle after a detected falling edge, i.e. while device clk is low.
- No frame resend and no device response parsing; the 0xFA response is received by ps2_keyb.

Optional Feature:
- Macro PS2_HOST_TX_TIMEOUT_EN.
- Defined: a counter resets on every falling edge and on entering REQ. If it reaches TIMEOUT_CLKS in REQ, DATA, PARITY, STOP, ACK or WAIT_IDLE:
  - both lines are released;
  - err=1, busy=0 next cycle, state=IDLE.
- Not defined: no counter. The FSM waits indefinitely; only wb_rst_i recovers it.

Decomposition:
- Package ps2_defs: FSM state encodings, status bit indices (BUSY=0, ERR=1), command constants (CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF).
- Sub-module ps2_line_sync: 2-flop synchroniser for clk and data plus falling-edge pulse output. It is reusable by ps2_keyb.

Test Plan:
1. Write 0xED with a device model that acks low → ps2_clk_oe_o high for exactly 10000 cycles. Data bits observed at device rising edges are 0,1,0,1,1,0,1,1,1, parity=1, stop=1. Final status 0x00.
2. Device model leaves data high at the ack clock → status 0x02 after WAIT_IDLE; the next write of 0xF4 clears it and status ends 0x00.
3. Write 0x12 while busy, during the DATA state → acked the next cycle; the serial stream still carries the original byte; status reads 0x01 until the frame ends.
4. Assert wb_rst_i during the PARITY state → on the next cycle ps2_clk_oe_o=0, ps2_data_oe_o=0 and wb_dat_o=0x00; a subsequent write of 0xFF transmits cleanly.
5. With PS2_HOST_TX_TIMEOUT_EN and no device clocks after REQ → err=1 and busy=0 exactly TIMEOUT_CLKS cycles after entering REQ; both lines released.
6. Read status during a frame → wb_dat_o=0x01, wb_ack_o high exactly one cycle; rx_inhibit_o high from acceptance until IDLE.
